serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor built around one full-adder cell, which is two half-adder stages plus a carry OR. It accepts two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first. When finished it presents the WIDTH-bit sum and the carry-out with a one-cycle done pulse. It sits in the arithmetic library as the area-optimised, multi-cycle successor to the combinational half adder.

---
 rtl/serial_adder.sv | 97 +++++++++
 tb/tb_serial_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell processes one bit per clock, LSB first.
// Subtraction is a + ~b + 1; carry then reads as the unsigned no-borrow flag.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_b_q, op_a_next, sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             cr_q, carry_q;
    logic             load, last_bit;
    logic             hs, hc, s_bit, c_bit;

    // Full adder from two half-adder stages plus the carry OR.
    assign hs    = op_a_q[0] ^ op_b_q[0];
    assign hc    = op_a_q[0] & op_b_q[0];
    assign s_bit = hs ^ cr_q;
    assign c_bit = hc | (hs & cr_q);

    // Operand A doubles as the sum shift register: each consumed LSB frees an MSB slot.
    if (WIDTH == 1) begin : g_w1
        assign op_a_next = s_bit;
    end else begin : g_wn
        assign op_a_next = {s_bit, op_a_q[WIDTH-1:1]};
    end

    assign load     = start && (state_q == StIdle || state_q == StDone);
    assign last_bit = (cnt_q == LastBit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy  = (state_q == StRun);
        done  = (state_q == StDone);
        sum   = sum_q;
        carry = carry_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            cr_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (load) begin
            op_a_q <= a;
            op_b_q <= sub ? ~b : b;
            cr_q   <= sub ? 1'b1 : cin;
            cnt_q  <= '0;
        end else if (state_q == StRun) begin
            op_a_q <= op_a_next;
            op_b_q <= op_b_q >> 1;
            cr_q   <= c_bit;
            cnt_q  <= cnt_q + CntW'(1);
            if (last_bit) begin
                sum_q   <= op_a_next;
                carry_q <= c_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for directed/random cases and a
// 4-bit instance for the exhaustive sweep, both checked against an arithmetic model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 0, sub8 = 0, cin8 = 0;
    logic [7:0] a8 = 0, b8 = 0, sum8;
    logic       carry8, busy8, done8;
    logic       start4 = 0, sub4 = 0, cin4 = 0;
    logic [3:0] a4 = 0, b4 = 0, sum4;
    logic       carry4, busy4, done4;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .carry(carry8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .carry(carry4), .busy(busy4), .done(done4)
    );

    typedef struct {
        logic [7:0] sum;
        logic       carry;
        int         due;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   e0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Reference: plain modular arithmetic on the operand values.
    function automatic exp_t model(input int w, input logic s, input int x, input int y,
                                   input logic c, input int due);
        exp_t r;
        int   m, t;
        m = 1 << w;
        if (s) begin
            t       = (x - y + m) % m;
            r.carry = (x >= y);
        end else begin
            t       = x + y + int'(c);
            r.carry = (t >= m);
            t       = t % m;
        end
        r.sum = 8'(t);
        r.due = due;
        return r;
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done8: got done with sum 0x%0h, required no done", sum8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("sum8", sum8, e.sum);
                check("carry8", carry8, e.carry);
                check("done8_cycle", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done4: got done with sum 0x%0h, required no done", sum4);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("sum4", sum4, e.sum);
                check("carry4", carry4, e.carry);
                check("done4_cycle", cyc, e.due);
            end
        end
    end

    task automatic check_zero8(input string tag);
        check({tag, "_sum"}, sum8, 0);
        check({tag, "_carry"}, carry8, 0);
        check({tag, "_busy"}, busy8, 0);
        check({tag, "_done"}, done8, 0);
    endtask

    task automatic issue8(input logic s, input logic [7:0] x, input logic [7:0] y,
                          input logic c);
        @(negedge clk);
        while (busy8) @(negedge clk);
        sub8 = s; a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        q8.push_back(model(8, s, int'(x), int'(y), c, cyc + 1 + 8));
        @(negedge clk);
        start8 = 1'b0;
        check("busy8_after_start", busy8, 1);
    endtask

    task automatic issue4(input logic s, input logic [3:0] x, input logic [3:0] y,
                          input logic c);
        @(negedge clk);
        while (busy4) @(negedge clk);
        sub4 = s; a4 = x; b4 = y; cin4 = c; start4 = 1'b1;
        q4.push_back(model(4, s, int'(x), int'(y), c, cyc + 1 + 4));
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic drain8();
        for (int i = 0; i < 200 && q8.size() != 0; i++) @(negedge clk);
        if (q8.size() != 0) begin
            n_total++;
            $display("FAIL drain8_timeout: got %0d results outstanding, required 0", q8.size());
            q8.delete();
        end
    endtask

    task automatic drain4();
        for (int i = 0; i < 200 && q4.size() != 0; i++) @(negedge clk);
        if (q4.size() != 0) begin
            n_total++;
            $display("FAIL drain4_timeout: got %0d results outstanding, required 0", q4.size());
            q4.delete();
        end
    endtask

    initial begin
        logic       rs, rc;
        logic [7:0] ra, rb;

        // Asynchronous reset, observed before the first clock edge.
        #1 rst = 1'b1;
        #1 check_zero8("reset_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_zero8("idle20");

        issue8(1'b0, 8'hFF, 8'h01, 1'b0); drain8();
        issue8(1'b0, 8'h35, 8'h4A, 1'b1); drain8();
        issue8(1'b1, 8'h10, 8'h03, 1'b0); drain8();
        issue8(1'b1, 8'h03, 8'h10, 1'b0); drain8();

        // start during RUN must be ignored along with the new operands.
        issue8(1'b0, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain8();

        // Back-to-back with start held high.
        @(negedge clk);
        while (busy8) @(negedge clk);
        sub8 = 1'b0; cin8 = 1'b0; a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        e0 = cyc + 1;
        q8.push_back(model(8, 1'b0, 1, 1, 1'b0, e0 + 8));
        @(negedge clk);
        a8 = 8'h02; b8 = 8'h02;
        q8.push_back(model(8, 1'b0, 2, 2, 1'b0, e0 + 9 + 8));
        repeat (9) @(negedge clk);
        start8 = 1'b0;
        drain8();

        // Reset during the 4th RUN cycle abandons the operation.
        issue8(1'b0, 8'h77, 8'h22, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero8("reset_midop");
        q8.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_zero8("after_reset");
        issue8(1'b0, 8'h0F, 8'h01, 1'b0); drain8();

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue8(rs, ra, rb, rc);
        end
        drain8();

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    issue4(1'b0, 4'(x), 4'(y), 1'(c));
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                issue4(1'b1, 4'(x), 4'(y), 1'($urandom_range(0, 1)));
        drain4();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
